ddr_queue_slot_scheduler: RTL and testbench
===========================================

// Module: ddr_queue_slot_scheduler
// PURPOSE
//  Slot-based DDR buffer manager and read scheduler for the per-queue DDR store.
//  - Write side: hands the DDR write master a slot address for each packet, then records its completion descriptor.
//  - Read side: picks a queue round-robin among those with a completed head slot and issues one read at a time to the read master.
//  - Sits between the write/read DDR masters and the queue logic.
// PARAMETERS
//  C_M_TARGET_SLAVE_BASE_ADDR  32'h0  DDR base byte address of queue 0
//  C_M_AXI_ADDR_WIDTH          32     address width
//  P_DDR_LOCAL_QUEUE           4      number of queues (one-hot queue vectors)
//  P_SLOT_BYTES                2048   bytes per slot (power of 2, >= max packet)
//  P_QUEUE_SLOTS               16     slots per queue (power of 2)
// PORTS
//  i_axis_clk          in   1     clock
//  i_axis_rst          in   1     synchronous active-high reset
//  i_wr_ddr_valid      in   1     slot request; held until o_wr_ddr_ready
//  i_wr_ddr_len        in   16    packet bytes
//  i_wr_ddr_queue      in   Q     one-hot target queue
//  o_wr_ddr_addr       out  AW    granted slot byte address
//  o_wr_ddr_ready      out  1     1-cycle grant pulse, o_wr_ddr_addr valid
//  i_wr_ddr_cpl_valid  in   1     write-complete descriptor
//  o_wr_ddr_cpl_ready  out  1     descriptor accept
//  i_wr_ddr_cpl_queue  in   Q     completed queue (one-hot)
//  i_wr_ddr_cpl_len    in   16    completed bytes
//  i_wr_ddr_cpl_addr   in   AW    completed slot address
//  i_wr_ddr_cpl_strb   in   8     last-beat byte strobe
//  o_rd_ddr_valid      out  1     read request
//  o_rd_ddr_addr       out  AW    read slot address
//  o_rd_ddr_len        out  16    read bytes
//  o_rd_ddr_strb       out  8     last-beat strobe
//  i_rd_ddr_ready      in   1     read master accept
//  i_rd_ddr_cpl        in   1     1-cycle pulse: issued read fully delivered
//  o_queue_empty       out  Q     bit q=1 when queue q holds no allocated slots
//  o_oversize_err      out  1     1-cycle pulse: request len > P_SLOT_BYTES
// BEHAVIOUR
//  Addressing:
//  - slot address = BASE + q*P_SLOT_BYTES*P_QUEUE_SLOTS + idx*P_SLOT_BYTES.
//  - Arithmetic is unsigned and truncated to AW.
//  Per-queue state:
//  - wptr, rptr: log2(SLOTS) bits, wrap modulo SLOTS.
//  - cnt: 0..SLOTS.
//  - Slot table entry: done bit, len[15:0], strb[7:0].
//  Reset values:
//  - ptrs, cnts, done bits, o_wr_ddr_ready, o_rd_ddr_valid, o_oversize_err, o_wr_ddr_cpl_ready = 0.
//  - addr/len/strb outputs = 0.
//  - o_queue_empty = all 1s.
//  - RR pointer = queue 0.
//  - o_wr_ddr_cpl_ready = 1 from the first cycle after reset.
//  Write allocation:
//  - In a cycle with i_wr_ddr_valid=1, o_wr_ddr_ready=0 and cnt[q] < SLOTS: next cycle o_wr_ddr_ready=1 with the address of wptr[q].
//  - In that same grant, wptr[q]++, cnt[q]++, done cleared.
//  - Latency is 1 cycle. The request is ignored while o_wr_ddr_ready=1, so there is never a double grant.
//  - Queue full: ready stays 0 until a slot frees; grant on the first free cycle.
//  - Queue select: multiple one-hot bits -> lowest set bit used. Zero bits -> request ignored.
//  - len > P_SLOT_BYTES: grant still issued, plus o_oversize_err pulse in the grant cycle.
//  Completion:
//  - On i_wr_ddr_cpl_valid, idx = addr[log2(SLOT_BYTES)+:log2(SLOTS)].
//  - Stores len and strb and sets done for that queue/idx.
//  - Completions may arrive out of slot order.
//  Read FSM (IDLE -> ISSUE -> WAIT_CPL -> IDLE):
//  - IDLE: scan queues starting at the RR pointer. The first q with cnt>0 and done[q][rptr] wins; move to ISSUE next cycle.
//  - ISSUE: o_rd_ddr_valid=1 with addr/len/strb held stable until i_rd_ddr_ready=1. After accept, valid=0 next cycle; go to WAIT_CPL.
//  - WAIT_CPL: on i_rd_ddr_cpl, rptr[q]++, cnt[q]--, done cleared; RR pointer = q+1 mod Q; return to IDLE.
//  - i_rd_ddr_cpl outside WAIT_CPL is ignored.
//  Boundary cases:
//  - Same-cycle grant and free on the same queue: cnt unchanged, both pointers advance.
//  - A completion and a grant may target the same queue in one cycle; both take effect.
//  - o_queue_empty[q] = (cnt[q]==0), registered.
//  - Reset mid-operation: all state returns to reset values on the next edge; outstanding requests are forgotten.
// TESTING
//  1. Q0 request len=1500 -> ready pulse 1 cycle later, addr=0x0000. Q1 request -> addr=0x8000 (defaults).
//  2. Fill Q2 with 16 grants; 17th request stalls. A completed read frees a slot -> grant at addr 0x10000 (wptr wrapped).
//  3. Q0 and Q3 both hold completed head slots -> reads issue Q0 then Q3, then Q0 again (round-robin).
//  4. Completions for Q1 slots 1 then 0 -> no read until slot 0 is done, then slot 0 and slot 1 are read in order.
//  5. i_rd_ddr_ready held low 5 cycles -> o_rd_ddr_valid/addr/len/strb stable throughout; one read issued only.
//  6. len=4000 -> grant plus o_oversize_err pulse. Assert reset during WAIT_CPL -> o_queue_empty=4'hF and valid=0 next cycle.

Source files
------------

// File: rtl/ddr_queue_slot_scheduler.sv
// Slot-based DDR buffer manager and round-robin read scheduler.
// Each queue owns a ring of fixed-size DDR slots. Writers get a slot address up front
// and report completion later. Reads drain each queue in slot order, one read in flight.
module ddr_queue_slot_scheduler #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          P_DDR_LOCAL_QUEUE          = 4,
    parameter int          P_SLOT_BYTES               = 2048,
    parameter int          P_QUEUE_SLOTS              = 16
) (
    input  logic                          i_axis_clk,
    input  logic                          i_axis_rst,
    input  logic                          i_wr_ddr_valid,
    input  logic [15:0]                   i_wr_ddr_len,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_wr_ddr_queue,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_wr_ddr_addr,
    output logic                          o_wr_ddr_ready,
    input  logic                          i_wr_ddr_cpl_valid,
    output logic                          o_wr_ddr_cpl_ready,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_wr_ddr_cpl_queue,
    input  logic [15:0]                   i_wr_ddr_cpl_len,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_wr_ddr_cpl_addr,
    input  logic [7:0]                    i_wr_ddr_cpl_strb,
    output logic                          o_rd_ddr_valid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_ddr_addr,
    output logic [15:0]                   o_rd_ddr_len,
    output logic [7:0]                    o_rd_ddr_strb,
    input  logic                          i_rd_ddr_ready,
    input  logic                          i_rd_ddr_cpl,
    output logic [P_DDR_LOCAL_QUEUE-1:0]  o_queue_empty,
    output logic                          o_oversize_err
);

    localparam int Q   = P_DDR_LOCAL_QUEUE;
    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int NS  = P_QUEUE_SLOTS;
    localparam int SBW = $clog2(P_SLOT_BYTES);
    localparam int PW  = $clog2(NS);
    localparam int QW  = (Q > 1) ? $clog2(Q) : 1;

    localparam logic [AW-1:0] BASE     = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(NS);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [16:0]   LEN_MAX  = 17'(P_SLOT_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_CPL} rd_state_t;

    // Slots are power-of-two sized and queue regions are contiguous, so addressing is shifts.
    function automatic logic [AW-1:0] slot_addr(input logic [QW-1:0] q, input logic [PW-1:0] idx);
        return BASE + (AW'(q) << (SBW + PW)) + (AW'(idx) << SBW);
    endfunction

    // Lowest set bit of a one-hot queue vector; tolerates malformed multi-hot inputs.
    function automatic logic [QW-1:0] low_bit(input logic [Q-1:0] v);
        logic [QW-1:0] r;
        r = '0;
        for (int i = Q - 1; i >= 0; i--) begin
            if (v[i]) r = QW'(i);
        end
        return r;
    endfunction

    rd_state_t     state, state_nxt;
    logic [PW-1:0] wptr [Q];
    logic [PW-1:0] rptr [Q];
    logic [PW:0]   cnt [Q];
    logic [PW:0]   cnt_nxt [Q];
    logic [NS-1:0] done [Q];
    logic [15:0]   len_tab [Q][NS];
    logic [7:0]    strb_tab [Q][NS];
    logic [QW-1:0] rr, rd_q, pick_q, wq, cq;
    logic [PW-1:0] cidx;
    logic          pick_found, grant, free, cpl_acc;
    logic          cpl_addr_unused;

    assign wq      = low_bit(i_wr_ddr_queue);
    assign grant   = i_wr_ddr_valid && !o_wr_ddr_ready && (|i_wr_ddr_queue) && (cnt[wq] < CNT_FULL);
    assign free    = (state == S_WAIT_CPL) && i_rd_ddr_cpl;
    assign cq      = low_bit(i_wr_ddr_cpl_queue);
    assign cpl_acc = i_wr_ddr_cpl_valid && o_wr_ddr_cpl_ready && (|i_wr_ddr_cpl_queue);
    assign cidx    = i_wr_ddr_cpl_addr[SBW +: PW];
    assign cpl_addr_unused = ^i_wr_ddr_cpl_addr;

    // Occupancy after this cycle's grant and free; a same-queue grant+free cancels out.
    always_comb begin
        for (int q = 0; q < Q; q++) begin
            cnt_nxt[q] = cnt[q];
            if (grant && wq == QW'(q)) cnt_nxt[q] = cnt_nxt[q] + CNT_ONE;
            if (free && rd_q == QW'(q)) cnt_nxt[q] = cnt_nxt[q] - CNT_ONE;
        end
    end

    // Per-queue ring pointers, occupancy, completion flags and empty status.
    always_ff @(posedge i_axis_clk) begin
        if (i_axis_rst) begin
            for (int q = 0; q < Q; q++) begin
                wptr[q] <= '0;
                rptr[q] <= '0;
                cnt[q]  <= '0;
                done[q] <= '0;
            end
            o_queue_empty <= '1;
        end else begin
            for (int q = 0; q < Q; q++) begin
                cnt[q]           <= cnt_nxt[q];
                o_queue_empty[q] <= (cnt_nxt[q] == '0);
            end
            if (grant) begin
                wptr[wq]           <= wptr[wq] + PTR_ONE;
                done[wq][wptr[wq]] <= 1'b0;
            end
            if (free) begin
                rptr[rd_q]             <= rptr[rd_q] + PTR_ONE;
                done[rd_q][rptr[rd_q]] <= 1'b0;
            end
            if (cpl_acc) done[cq][cidx] <= 1'b1;
        end
    end

    // Completion descriptors; the done flag gates use, so these need no reset.
    always_ff @(posedge i_axis_clk) begin
        if (cpl_acc) begin
            len_tab[cq][cidx]  <= i_wr_ddr_cpl_len;
            strb_tab[cq][cidx] <= i_wr_ddr_cpl_strb;
        end
    end

    // Write-side grant pulse, slot address, oversize flag and descriptor acceptance.
    always_ff @(posedge i_axis_clk) begin
        if (i_axis_rst) begin
            o_wr_ddr_ready     <= 1'b0;
            o_wr_ddr_addr      <= '0;
            o_oversize_err     <= 1'b0;
            o_wr_ddr_cpl_ready <= 1'b0;
        end else begin
            o_wr_ddr_ready     <= grant;
            o_oversize_err     <= grant && ({1'b0, i_wr_ddr_len} > LEN_MAX);
            o_wr_ddr_cpl_ready <= 1'b1;
            if (grant) o_wr_ddr_addr <= slot_addr(wq, wptr[wq]);
        end
    end

    // Round-robin scan from rr for the first queue whose head slot is complete.
    always_comb begin
        logic [QW:0]   qsum;
        logic [QW-1:0] qv;
        pick_found = 1'b0;
        pick_q     = '0;
        qsum       = '0;
        qv         = '0;
        for (int i = 0; i < Q; i++) begin
            qsum = {1'b0, rr} + (QW+1)'(i);
            if (qsum >= (QW+1)'(Q)) qsum = qsum - (QW+1)'(Q);
            qv = qsum[QW-1:0];
            if (!pick_found && cnt[qv] != '0 && done[qv][rptr[qv]]) begin
                pick_found = 1'b1;
                pick_q     = qv;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge i_axis_clk) begin
        if (i_axis_rst) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Read FSM next state; the request is valid for exactly the ISSUE state.
    always_comb begin
        state_nxt      = state;
        o_rd_ddr_valid = 1'b0;
        case (state)
            S_IDLE:     if (pick_found) state_nxt = S_ISSUE;
            S_ISSUE: begin
                o_rd_ddr_valid = 1'b1;
                if (i_rd_ddr_ready) state_nxt = S_WAIT_CPL;
            end
            S_WAIT_CPL: if (i_rd_ddr_cpl) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Latch the chosen slot's request fields and advance the round-robin pointer on free.
    always_ff @(posedge i_axis_clk) begin
        if (i_axis_rst) begin
            rd_q          <= '0;
            rr            <= '0;
            o_rd_ddr_addr <= '0;
            o_rd_ddr_len  <= '0;
            o_rd_ddr_strb <= '0;
        end else begin
            if (state == S_IDLE && pick_found) begin
                rd_q          <= pick_q;
                o_rd_ddr_addr <= slot_addr(pick_q, rptr[pick_q]);
                o_rd_ddr_len  <= len_tab[pick_q][rptr[pick_q]];
                o_rd_ddr_strb <= strb_tab[pick_q][rptr[pick_q]];
            end
            if (free) rr <= (rd_q == QW'(Q - 1)) ? '0 : rd_q + QW'(1);
        end
    end

endmodule

// File: tb/tb_ddr_queue_slot_scheduler.sv
// Directed bench for ddr_queue_slot_scheduler: a vector table for write-side grants,
// then hand-written sequences for stall, round-robin, ordering, backpressure and reset.
module tb_ddr_queue_slot_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_len = '0;
    logic [3:0]  wr_queue = '0;
    logic [31:0] wr_addr;
    logic        wr_ready;
    logic        cpl_valid = 1'b0;
    logic        cpl_ready;
    logic [3:0]  cpl_queue = '0;
    logic [15:0] cpl_len = '0;
    logic [31:0] cpl_addr = '0;
    logic [7:0]  cpl_strb = '0;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [15:0] rd_len;
    logic [7:0]  rd_strb;
    logic        rd_ready = 1'b0;
    logic        rd_cpl = 1'b0;
    logic [3:0]  q_empty;
    logic        oversize;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_queue_slot_scheduler dut (
        .i_axis_clk         (clk),
        .i_axis_rst         (rst),
        .i_wr_ddr_valid     (wr_valid),
        .i_wr_ddr_len       (wr_len),
        .i_wr_ddr_queue     (wr_queue),
        .o_wr_ddr_addr      (wr_addr),
        .o_wr_ddr_ready     (wr_ready),
        .i_wr_ddr_cpl_valid (cpl_valid),
        .o_wr_ddr_cpl_ready (cpl_ready),
        .i_wr_ddr_cpl_queue (cpl_queue),
        .i_wr_ddr_cpl_len   (cpl_len),
        .i_wr_ddr_cpl_addr  (cpl_addr),
        .i_wr_ddr_cpl_strb  (cpl_strb),
        .o_rd_ddr_valid     (rd_valid),
        .o_rd_ddr_addr      (rd_addr),
        .o_rd_ddr_len       (rd_len),
        .o_rd_ddr_strb      (rd_strb),
        .i_rd_ddr_ready     (rd_ready),
        .i_rd_ddr_cpl       (rd_cpl),
        .o_queue_empty      (q_empty),
        .o_oversize_err     (oversize)
    );

    typedef struct {
        logic [3:0]  queue;
        logic [15:0] len;
        logic        exp_rdy;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        cpl_valid = 1'b0;
        rd_ready = 1'b0;
        rd_cpl = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic request(input string name, input logic [3:0] q, input logic [15:0] len,
                           input logic [31:0] exp_addr);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_queue = q;
        wr_len = len;
        do begin
            tick();
            n++;
        end while (!wr_ready && n < 40);
        chk({name, " grant"}, 64'(wr_ready), 64'd1);
        chk({name, " addr"}, 64'(wr_addr), 64'(exp_addr));
        wr_valid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] q, input logic [31:0] addr, input logic [15:0] len,
                            input logic [7:0] strb);
        cpl_valid = 1'b1;
        cpl_queue = q;
        cpl_addr = addr;
        cpl_len = len;
        cpl_strb = strb;
        tick();
        cpl_valid = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        while (!rd_valid && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (!rd_valid) begin
            errors++;
            $display("FAIL %s: read request absent after %0d cycles, expected valid=1", name, n);
        end
    endtask

    task automatic read(input string name, input logic [31:0] exp_addr, input logic [15:0] exp_len,
                        input logic [7:0] exp_strb);
        wait_rd(name);
        chk({name, " addr"}, 64'(rd_addr), 64'(exp_addr));
        chk({name, " len"}, 64'(rd_len), 64'(exp_len));
        chk({name, " strb"}, 64'(rd_strb), 64'(exp_strb));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk({name, " valid drop"}, 64'(rd_valid), 64'd0);
        rd_cpl = 1'b1;
        tick();
        rd_cpl = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'b0001, 16'd1500, 1'b1, 32'h0000_0000, 1'b0};
        vecs[1] = '{4'b0010, 16'd64,   1'b1, 32'h0000_8000, 1'b0};
        vecs[2] = '{4'b0001, 16'd2048, 1'b1, 32'h0000_0800, 1'b0};
        vecs[3] = '{4'b0110, 16'd100,  1'b1, 32'h0000_8800, 1'b0};
        vecs[4] = '{4'b1000, 16'd4000, 1'b1, 32'h0001_8000, 1'b1};
        vecs[5] = '{4'b0100, 16'd2049, 1'b1, 32'h0001_0000, 1'b1};
        vecs[6] = '{4'b0000, 16'd500,  1'b0, 32'h0000_0000, 1'b0};
        vecs[7] = '{4'b1100, 16'd0,    1'b1, 32'h0001_0800, 1'b0};

        // Reset state while reset is held.
        tick();
        tick();
        chk("rst wr_ready", 64'(wr_ready), 64'd0);
        chk("rst wr_addr", 64'(wr_addr), 64'd0);
        chk("rst rd_valid", 64'(rd_valid), 64'd0);
        chk("rst rd_addr", 64'(rd_addr), 64'd0);
        chk("rst rd_len", 64'(rd_len), 64'd0);
        chk("rst rd_strb", 64'(rd_strb), 64'd0);
        chk("rst empty", 64'(q_empty), 64'hF);
        chk("rst oversize", 64'(oversize), 64'd0);
        chk("rst cpl_ready", 64'(cpl_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("cpl_ready after rst", 64'(cpl_ready), 64'd1);

        // Grant table: addressing, lowest-bit select, zero select, oversize boundary.
        foreach (vecs[i]) begin
            wr_valid = 1'b1;
            wr_queue = vecs[i].queue;
            wr_len = vecs[i].len;
            tick();
            chk($sformatf("vec%0d ready", i), 64'(wr_ready), 64'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy) chk($sformatf("vec%0d addr", i), 64'(wr_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("vec%0d oversize", i), 64'(oversize), 64'(vecs[i].exp_err));
            wr_valid = 1'b0;
            tick();
            chk($sformatf("vec%0d ready drop", i), 64'(wr_ready), 64'd0);
            chk($sformatf("vec%0d oversize drop", i), 64'(oversize), 64'd0);
        end
        chk("table empty", 64'(q_empty), 64'h0);

        // Fill Q2, stall the 17th request, free one slot and see the wrapped grant.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            request($sformatf("fill%0d", i), 4'b0100, 16'd64, 32'h0001_0000 + 32'(i) * 32'h800);
        end
        wr_valid = 1'b1;
        wr_queue = 4'b0100;
        wr_len = 16'd64;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("full stall%0d", i), 64'(wr_ready), 64'd0);
        end
        chk("full empty", 64'(q_empty), 64'h0 | 64'hB);
        complete(4'b0100, 32'h0001_0000, 16'd100, 8'h0F);
        read("full read", 32'h0001_0000, 16'd100, 8'h0F);
        chk("full no early grant", 64'(wr_ready), 64'd0);
        tick();
        chk("wrap grant", 64'(wr_ready), 64'd1);
        chk("wrap addr", 64'(wr_addr), 64'h0001_0000);
        wr_valid = 1'b0;

        // Round-robin between Q0 and Q3.
        do_reset();
        request("rr q0a", 4'b0001, 16'd10, 32'h0000_0000);
        request("rr q3", 4'b1000, 16'd20, 32'h0001_8000);
        request("rr q0b", 4'b0001, 16'd30, 32'h0000_0800);
        complete(4'b0001, 32'h0000_0000, 16'd10, 8'h01);
        complete(4'b1000, 32'h0001_8000, 16'd20, 8'h03);
        complete(4'b0001, 32'h0000_0800, 16'd30, 8'h07);
        read("rr first q0", 32'h0000_0000, 16'd10, 8'h01);
        read("rr then q3", 32'h0001_8000, 16'd20, 8'h03);
        read("rr back q0", 32'h0000_0800, 16'd30, 8'h07);

        // Out-of-order completions on Q1: the head slot gates the read.
        do_reset();
        request("ooo s0", 4'b0010, 16'd300, 32'h0000_8000);
        request("ooo s1", 4'b0010, 16'd200, 32'h0000_8800);
        complete(4'b0010, 32'h0000_8800, 16'd200, 8'h03);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ooo hold%0d", i), 64'(rd_valid), 64'd0);
        end
        complete(4'b0010, 32'h0000_8000, 16'd300, 8'hFF);
        read("ooo slot0", 32'h0000_8000, 16'd300, 8'hFF);
        read("ooo slot1", 32'h0000_8800, 16'd200, 8'h03);
        chk("ooo empty", 64'(q_empty), 64'hF);

        // Backpressure: request fields hold while ready is low; stray cpl ignored.
        do_reset();
        request("bp req", 4'b0001, 16'd1000, 32'h0000_0000);
        complete(4'b0001, 32'h0000_0000, 16'd1000, 8'h3F);
        wait_rd("bp wait");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp valid%0d", i), 64'(rd_valid), 64'd1);
            chk($sformatf("bp addr%0d", i), 64'(rd_addr), 64'h0);
            chk($sformatf("bp len%0d", i), 64'(rd_len), 64'd1000);
            chk($sformatf("bp strb%0d", i), 64'(rd_strb), 64'h3F);
            rd_cpl = (i == 2);
            tick();
            rd_cpl = 1'b0;
        end
        chk("bp still valid", 64'(rd_valid), 64'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp single issue%0d", i), 64'(rd_valid), 64'd0);
            tick();
        end
        chk("bp not freed yet", 64'(q_empty), 64'hE);
        rd_cpl = 1'b1;
        tick();
        rd_cpl = 1'b0;
        chk("bp freed", 64'(q_empty), 64'hF);
        tick();
        tick();
        chk("bp idle", 64'(rd_valid), 64'd0);

        // Oversize pulse, then reset during WAIT_CPL.
        do_reset();
        request("big req", 4'b0001, 16'd4000, 32'h0000_0000);
        chk("big oversize", 64'(oversize), 64'd1);
        tick();
        chk("big oversize pulse", 64'(oversize), 64'd0);
        complete(4'b0001, 32'h0000_0000, 16'd4000, 8'hFF);
        wait_rd("big wait");
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst empty", 64'(q_empty), 64'hF);
        chk("midrst rd_valid", 64'(rd_valid), 64'd0);
        chk("midrst cpl_ready", 64'(cpl_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("midrst cpl_ready back", 64'(cpl_ready), 64'd1);
        rd_cpl = 1'b1;
        tick();
        rd_cpl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst quiet%0d", i), 64'(rd_valid), 64'd0);
            tick();
        end
        chk("midrst empty kept", 64'(q_empty), 64'hF);
        request("midrst fresh", 4'b0001, 16'd64, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
